// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating-counter direction prediction.
// Lookups are combinational from current state; updates and statistics are registered.
module branch_target_predictor #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned CNT_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispred,
  input  logic              flush_all,
  output logic [31:0]       lookup_cnt,
  output logic [31:0]       mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic [ENTRIES-1:0]              valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [ENTRIES-1:0][ADDR_W-1:0]  tgt_q, tgt_d;
  logic [ENTRIES-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]                     lookup_cnt_q, lookup_cnt_d;
  logic [31:0]                     mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;

  assign lk_idx = lookup_pc[IDX_W-1:0];
  assign lk_tag = lookup_pc[ADDR_W-1:IDX_W];
  assign up_idx = upd_pc[IDX_W-1:0];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W];

  // Prediction reads only registered state, so a same-cycle update is seen next cycle.
  assign pred_hit     = lookup_valid && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken   = pred_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_next_pc = pred_taken ? tgt_q[lk_idx] : lookup_pc + ADDR_W'(1);

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (flush_all) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (cnt_q[up_idx] != CNT_MAX) cnt_d[up_idx] = cnt_q[up_idx] + CNT_W'(1);
          tgt_d[up_idx] = upd_target;
        end else if (cnt_q[up_idx] != '0) begin
          cnt_d[up_idx] = cnt_q[up_idx] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = upd_target;
        cnt_d[up_idx]   = CNT_WEAK;
      end
    end
  end

  always_comb begin
    lookup_cnt_d  = lookup_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (lookup_valid && (lookup_cnt_q != '1)) lookup_cnt_d = lookup_cnt_q + 32'd1;
    if (upd_valid && upd_mispred && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      tag_q         <= '0;
      tgt_q         <= '0;
      cnt_q         <= '0;
      lookup_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      tgt_q         <= tgt_d;
      cnt_q         <= cnt_d;
      lookup_cnt_q  <= lookup_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign lookup_cnt  = lookup_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: allocation, counter saturation,
// flush priority, PC wrap, same-cycle lookup/update ordering and async reset.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid;
  logic [29:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [29:0] pred_next_pc;
  logic        upd_valid;
  logic [29:0] upd_pc;
  logic        upd_taken;
  logic [29:0] upd_target;
  logic        upd_mispred;
  logic        flush_all;
  logic [31:0] lookup_cnt;
  logic [31:0] mispred_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  branch_target_predictor #(
    .ENTRIES(32),
    .ADDR_W (30),
    .CNT_W  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_valid(lookup_valid),
    .lookup_pc   (lookup_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_next_pc(pred_next_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_mispred (upd_mispred),
    .flush_all   (flush_all),
    .lookup_cnt  (lookup_cnt),
    .mispred_cnt (mispred_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pred(input string tag, input logic h, input logic t, input logic [29:0] n);
    chk({tag, ".hit"},   32'(pred_hit),     32'(h));
    chk({tag, ".taken"}, 32'(pred_taken),   32'(t));
    chk({tag, ".next"},  32'(pred_next_pc), 32'(n));
  endtask

  // Combinational lookup between edges; lookup_valid never spans a rising edge here.
  task automatic lookup(input string tag, input logic [29:0] pc,
                        input logic h, input logic t, input logic [29:0] n);
    @(negedge clk);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    #1;
    chk_pred(tag, h, t, n);
    lookup_valid = 1'b0;
  endtask

  task automatic update(input logic [29:0] pc, input logic tk,
                        input logic [29:0] tgt, input logic mp);
    @(negedge clk);
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_taken   = tk;
    upd_target  = tgt;
    upd_mispred = mp;
    @(posedge clk);
    #1;
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; lookup_valid = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_mispred = 1'b0; flush_all = 1'b0;

    // Outputs during reset
    #8;
    lookup_valid = 1'b1; lookup_pc = 30'h40;
    #1;
    chk_pred("in_reset", 1'b0, 1'b0, 30'h41);
    lookup_valid = 1'b0;
    #14 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_lookup_cnt",  lookup_cnt,  32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);

    lookup("empty_0x40", 30'h40, 1'b0, 1'b0, 30'h41);

    // Allocate on taken miss, weakly taken
    update(30'h40, 1'b1, 30'h10, 1'b1);
    lookup("alloc_0x40", 30'h40, 1'b1, 1'b1, 30'h10);
    lookup("alias_0x60", 30'h60, 1'b0, 1'b0, 30'h61);
    chk("mispred_1", mispred_cnt, 32'd1);

    // Counter walk: 2 -> 1 -> 0 -> 0 -> 0 -> 1 -> 2 -> 3 -> 3 -> 2 -> 1
    update(30'h40, 1'b0, 30'h99, 1'b1);
    lookup("cnt1_dn", 30'h40, 1'b1, 1'b0, 30'h41);
    update(30'h40, 1'b0, 30'h99, 1'b1);
    lookup("cnt0", 30'h40, 1'b1, 1'b0, 30'h41);
    update(30'h40, 1'b0, 30'h99, 1'b0);
    update(30'h40, 1'b0, 30'h99, 1'b0);
    update(30'h40, 1'b1, 30'h10, 1'b1);
    lookup("cnt_floor", 30'h40, 1'b1, 1'b0, 30'h41);
    update(30'h40, 1'b1, 30'h10, 1'b0);
    lookup("cnt2_up", 30'h40, 1'b1, 1'b1, 30'h10);
    update(30'h40, 1'b1, 30'h10, 1'b0);
    update(30'h40, 1'b1, 30'h22, 1'b0);
    lookup("cnt3_tgt", 30'h40, 1'b1, 1'b1, 30'h22);
    update(30'h40, 1'b0, 30'h99, 1'b1);
    lookup("cnt_ceiling", 30'h40, 1'b1, 1'b1, 30'h22);
    update(30'h40, 1'b0, 30'h99, 1'b0);
    lookup("cnt1_again", 30'h40, 1'b1, 1'b0, 30'h41);

    // Not-taken miss must not allocate or disturb the resident entry
    update(30'h60, 1'b0, 30'h33, 1'b0);
    lookup("nt_miss_0x60", 30'h60, 1'b0, 1'b0, 30'h61);
    lookup("nt_miss_keep", 30'h40, 1'b1, 1'b0, 30'h41);
    chk("mispred_5", mispred_cnt, 32'd5);

    // Three lookup cycles
    chk("lookup_cnt_0", lookup_cnt, 32'd0);
    @(negedge clk);
    lookup_valid = 1'b1; lookup_pc = 30'h123;
    repeat (3) @(posedge clk);
    #1 lookup_valid = 1'b0;
    chk("lookup_cnt_3", lookup_cnt, 32'd3);

    // Flush wins over same-cycle taken update
    @(negedge clk);
    flush_all = 1'b1;
    upd_valid = 1'b1; upd_pc = 30'h80; upd_taken = 1'b1; upd_target = 30'h55;
    @(posedge clk); #1;
    flush_all = 1'b0; upd_valid = 1'b0;
    lookup("flush_0x80", 30'h80, 1'b0, 1'b0, 30'h81);
    lookup("flush_0x40", 30'h40, 1'b0, 1'b0, 30'h41);
    chk("flush_lookup_cnt", lookup_cnt, 32'd3);
    chk("flush_mispred_cnt", mispred_cnt, 32'd5);

    // PC wrap on miss, then same-cycle lookup/update ordering
    lookup("wrap", 30'h3FFF_FFFF, 1'b0, 1'b0, 30'h0);
    @(negedge clk);
    lookup_valid = 1'b1; lookup_pc = 30'h3FFF_FFFF;
    upd_valid = 1'b1; upd_pc = 30'h3FFF_FFFF; upd_taken = 1'b1; upd_target = 30'h7;
    #1;
    chk_pred("same_cyc_old", 1'b0, 1'b0, 30'h0);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    chk_pred("same_cyc_new", 1'b1, 1'b1, 30'h7);
    lookup_valid = 1'b0;
    chk("lookup_cnt_4", lookup_cnt, 32'd4);

    // Asynchronous reset pulse between edges, with an update in flight
    @(negedge clk);
    lookup_valid = 1'b1; lookup_pc = 30'h3FFF_FFFF;
    upd_valid = 1'b1; upd_pc = 30'h40; upd_taken = 1'b1; upd_target = 30'h44;
    #1;
    chk("pre_rst_hit", 32'(pred_hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_pred("async_rst", 1'b0, 1'b0, 30'h0);
    chk("async_rst_mispred", mispred_cnt, 32'd0);
    chk("async_rst_lookup",  lookup_cnt,  32'd0);
    upd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_hit", 32'(pred_hit), 32'd0);
    lookup_valid = 1'b0;
    lookup("post_rst_0x40", 30'h40, 1'b0, 1'b0, 30'h41);

    // Updates resume after reset
    update(30'h40, 1'b1, 30'h9, 1'b1);
    lookup("resume", 30'h40, 1'b1, 1'b1, 30'h9);
    chk("resume_mispred", mispred_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL provide parameter ENTRIES, default 32: table depth; power of two, at least 4.
REQ-002 SHALL provide parameter ADDR_W, default 30: word-address width, matching cache word addressing.
REQ-003 SHALL provide parameter CNT_W, default 2: saturating-counter width, at least 1.
REQ-004 SHALL provide port clk, input, 1: single clock, all state updates on its rising edge.
REQ-005 SHALL provide port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL provide port lookup_valid, input, 1: IF-stage lookup request qualifier.
REQ-007 SHALL provide port lookup_pc, input, ADDR_W: word address being fetched.
REQ-008 SHALL provide port pred_hit, output, 1: lookup_pc matches a valid entry.
REQ-009 SHALL provide port pred_taken, output, 1: branch predicted taken.
REQ-010 SHALL provide port pred_next_pc, output, ADDR_W: predicted next fetch word address.
REQ-011 SHALL provide port upd_valid, input, 1: resolved control-transfer update strobe, one update per asserted cycle.
REQ-012 SHALL provide port upd_pc, input, ADDR_W: word address of the resolved instruction.
REQ-013 SHALL provide port upd_taken, input, 1: actual outcome.
REQ-014 SHALL provide port upd_target, input, ADDR_W: actual target word address.
REQ-015 SHALL provide port upd_mispred, input, 1: pipeline flushed due to this instruction.
REQ-016 SHALL provide port flush_all, input, 1: synchronous invalidate of the whole table.
REQ-017 SHALL provide port lookup_cnt, output, 32: count of lookup_valid cycles.
REQ-018 SHALL provide port mispred_cnt, output, 32: count of updates with upd_mispred set.

Function
REQ-019 SHALL derive IDX_W = log2(ENTRIES).
REQ-020 SHALL use index = pc[IDX_W-1:0] and tag = pc[ADDR_W-1:IDX_W].
REQ-021 SHALL hold one valid bit, tag, target and CNT_W-bit counter per entry; the table is direct-mapped.
REQ-022 SHALL drive lookup outputs combinationally in the same cycle from current state, with no bypass of same-cycle updates.
REQ-023 SHALL set pred_hit = lookup_valid AND valid[idx] AND tag match.
REQ-024 SHALL set pred_taken = pred_hit AND counter MSB.
REQ-025 SHALL set pred_next_pc = stored target when pred_taken, else lookup_pc+1 modulo 2^ADDR_W, so all-ones wraps to 0.
REQ-026 SHALL allocate on an update miss (invalid or tag mismatch) only when upd_taken=1: set valid=1, write tag and target, and initialise the counter to 2^(CNT_W-1) (weakly taken); an existing conflicting entry is overwritten.
REQ-027 SHALL make no table change on an update miss with upd_taken=0.
REQ-028 SHALL, on an update hit with upd_taken=1, increment the counter saturating at 2^CNT_W-1 and overwrite the target with upd_target.
REQ-029 SHALL, on an update hit with upd_taken=0, decrement the counter saturating at 0 and leave the target unchanged.
REQ-030 SHALL give flush_all priority over a same-cycle update: all valid bits clear, update discarded, counters and targets untouched.
REQ-031 SHALL increment lookup_cnt when lookup_valid=1, saturating at 2^32-1.
REQ-032 SHALL increment mispred_cnt when upd_valid AND upd_mispred, saturating at 2^32-1; flush_all SHALL NOT clear either counter.
REQ-033 SHALL, when a lookup and an update hit the same index in one cycle, return the pre-update state for the lookup; the update is visible from the next cycle.

Reset
REQ-034 SHALL, while rst_n=0, immediately clear all valid bits, counters, targets, tags, lookup_cnt and mispred_cnt, independent of clk.
REQ-035 SHALL, during and after reset, drive pred_hit=0, pred_taken=0 and pred_next_pc=lookup_pc+1.
REQ-036 SHALL, on reset asserted mid-update, leave no partial entry: the table is empty once rst_n rises.
REQ-037 SHALL begin updating on the first rising clk edge after rst_n deasserts.

Verification (ENTRIES=32, ADDR_W=30, CNT_W=2)
REQ-038 SHALL check: after reset, lookup pc=0x40 -> hit=0, taken=0, next=0x41.
REQ-039 SHALL check: update pc=0x40, taken=1, target=0x10; next-cycle lookup 0x40 -> hit=1, taken=1, next=0x10; lookup 0x60 (same index, other tag) -> hit=0.
REQ-040 SHALL check: from weakly taken, two not-taken updates -> counter 0, taken=0; two further not-taken updates -> counter stays 0; three taken updates -> counter 3, a fourth stays 3.
REQ-041 SHALL check: flush_all and a taken update to pc 0x80 in the same cycle -> lookup 0x80 hit=0; lookup_cnt is unchanged by the flush.
REQ-042 SHALL check: lookup pc=0x3FFFFFFF on miss -> next=0x0; lookup and update to the same index in one cycle -> old prediction that cycle, new prediction the next cycle.
REQ-043 SHALL check: rst_n pulsed low between clock edges while mispred_cnt=5 -> all outputs clear at once, mispred_cnt=0, and no clock edge is required.
